// File: rtl/step_pulse_out.sv
// step_pulse_out: turns single-cycle step strobes into timed STEP/DIR pin pulses and tracks signed axis position.
module step_pulse_out #(
  parameter int CNT_W = 16,
  parameter int POS_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step_stb,
  input  logic             dir_in,
  input  logic [CNT_W-1:0] pulse_len,
  input  logic [CNT_W-1:0] setup_len,
  input  logic             pos_load,
  input  logic [POS_W-1:0] pos_val,
  input  logic             clr_err,
  output logic             step_out,
  output logic             dir_out,
  output logic [POS_W-1:0] position,
  output logic             busy,
  output logic             overrun
);
  typedef enum logic [1:0] {IDLE, SETUP, PULSE, LOW} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, pl, sl;
  logic [POS_W-1:0] pos_q, pos_d;
  logic req_q, req_d, req_dir_q, req_dir_d, step_q, step_d, dir_q, dir_d, ovr_q, ovr_d;
  logic consume, rise, drop;
  // counter reload values are L-1 with a zero length treated as one
  assign pl = (pulse_len == '0) ? '0 : pulse_len - CNT_W'(1);
  assign sl = (setup_len == '0) ? '0 : setup_len - CNT_W'(1);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    dir_d   = dir_q;
    consume = 1'b0;
    rise    = 1'b0;
    case (state_q)
      IDLE: if (req_q) begin
        consume = 1'b1;
        if (req_dir_q == dir_q) rise = 1'b1;
        else begin
          dir_d   = req_dir_q;
          state_d = SETUP;
          cnt_d   = sl;
        end
      end
      SETUP: if (cnt_q == '0) rise = 1'b1; else cnt_d = cnt_q - CNT_W'(1);
      PULSE: if (cnt_q == '0) begin
        step_d  = 1'b0;
        state_d = LOW;
        cnt_d   = pl;
      end else cnt_d = cnt_q - CNT_W'(1);
      LOW: if (cnt_q == '0) state_d = IDLE; else cnt_d = cnt_q - CNT_W'(1);
      default: state_d = IDLE;
    endcase
    if (rise) begin
      state_d = PULSE;
      step_d  = 1'b1;
      cnt_d   = pl;
    end
    drop      = step_stb & req_q & ~consume;
    req_d     = step_stb | (req_q & ~consume);
    req_dir_d = (step_stb & ~drop) ? dir_in : req_dir_q;
    ovr_d     = drop | (ovr_q & ~clr_err);
    pos_d     = pos_load ? pos_val : rise ? (dir_d ? pos_q + POS_W'(1) : pos_q - POS_W'(1)) : pos_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      req_dir_q <= 1'b0;
      step_q    <= 1'b0;
      dir_q     <= 1'b0;
      ovr_q     <= 1'b0;
      pos_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      req_dir_q <= req_dir_d;
      step_q    <= step_d;
      dir_q     <= dir_d;
      ovr_q     <= ovr_d;
      pos_q     <= pos_d;
    end
  end
  assign step_out = step_q;
  assign dir_out  = dir_q;
  assign position = pos_q;
  assign overrun  = ovr_q;
  assign busy     = (state_q != IDLE) | req_q;
endmodule

// File: tb/tb_step_pulse_out.sv
// tb_step_pulse_out: randomized and directed checks of step_pulse_out against an event-schedule reference model.
module tb_step_pulse_out;
  logic clk = 1'b0, reset = 1'b1, step_stb = 1'b0, dir_in = 1'b0, pos_load = 1'b0, clr_err = 1'b0;
  logic [15:0] pulse_len = 16'd1, setup_len = 16'd1;
  logic [31:0] pos_val = '0;
  logic step_out, dir_out, busy, overrun;
  logic [31:0] position;
  int checks = 0, failures = 0;

  step_pulse_out #(.CNT_W(16), .POS_W(32)) dut (
    .clk(clk), .reset(reset), .step_stb(step_stb), .dir_in(dir_in),
    .pulse_len(pulse_len), .setup_len(setup_len), .pos_load(pos_load),
    .pos_val(pos_val), .clr_err(clr_err), .step_out(step_out), .dir_out(dir_out),
    .position(position), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // reference: absolute edge times of the next rise, fall and return to idle
  logic e_step = 0, e_dir = 0, e_ovr = 0, e_busy = 0, p_req = 0, p_dir = 0;
  logic [31:0] e_pos = '0;
  longint n = 0, t_rise = -1, t_fall = -1, t_idle = -1;
  always @(posedge clk) begin
    longint lp, ls;
    logic cons, rose, drop;
    n = n + 1;
    if (reset) begin
      e_step = 0; e_dir = 0; e_pos = '0; e_ovr = 0; p_req = 0;
      t_rise = -1; t_fall = -1; t_idle = -1;
    end else begin
      lp = (pulse_len == 0) ? 1 : longint'(pulse_len);
      ls = (setup_len == 0) ? 1 : longint'(setup_len);
      cons = p_req && (n > t_idle);
      rose = 0;
      if (cons) begin
        t_idle = 64'h7fff_ffff_ffff_ffff;
        if (p_dir != e_dir) begin e_dir = p_dir; t_rise = n + ls; end
        else t_rise = n;
      end
      if (n == t_rise) begin e_step = 1; t_fall = n + lp; rose = 1; end
      if (n == t_fall) begin e_step = 0; t_idle = n + lp; end
      e_pos = pos_load ? pos_val : rose ? (e_dir ? e_pos + 1 : e_pos - 1) : e_pos;
      drop = step_stb && p_req && !cons;
      if (step_stb && !drop) begin p_req = 1; p_dir = dir_in; end
      else if (cons) p_req = 0;
      e_ovr = drop | (e_ovr & ~clr_err);
    end
    e_busy = p_req || (n < t_idle);
  end

  task automatic idle_inputs();
    step_stb = 0; pos_load = 0; clr_err = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    checks++;
    if ({step_out, dir_out, busy, overrun, position} !== 36'd0) begin
      failures++;
      $display("FAIL reset_values got=%h exp=0", {step_out, dir_out, busy, overrun, position});
    end
  endtask

  task automatic test_single();
    int highs = 0, busy_low = -1;
    pulse_len = 3; dir_in = 0; step_stb = 1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); @(negedge clk);
      step_stb = 0;
      highs += int'(step_out);
      if (!busy && busy_low < 0) busy_low = k;
      checks++;
      if ({step_out, dir_out, busy, overrun, position} !== {e_step, e_dir, e_busy, e_ovr, e_pos}) begin
        failures++;
        $display("FAIL single_cycle%0d got=%h exp=%h", k, {step_out, dir_out, busy, overrun, position}, {e_step, e_dir, e_busy, e_ovr, e_pos});
      end
    end
    checks++;
    if (highs != 3 || position !== 32'hffff_ffff || dir_out !== 1'b0 || busy_low != 7) begin
      failures++;
      $display("FAIL single_summary highs=%0d pos=%h dir=%b busy_low=%0d exp 3 ffffffff 0 7", highs, position, dir_out, busy_low);
    end
  endtask

  task automatic test_dir_change();
    int dir_k = -1, rise_k = -1;
    logic [31:0] start = position;
    setup_len = 5; pulse_len = 2; dir_in = 1; step_stb = 1;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk); @(negedge clk);
      step_stb = 0;
      if (dir_out && dir_k < 0) dir_k = k;
      if (step_out && rise_k < 0) rise_k = k;
      checks++;
      if ({step_out, dir_out, busy, overrun, position} !== {e_step, e_dir, e_busy, e_ovr, e_pos}) begin
        failures++;
        $display("FAIL dirchg_cycle%0d got=%h exp=%h", k, {step_out, dir_out, busy, overrun, position}, {e_step, e_dir, e_busy, e_ovr, e_pos});
      end
    end
    checks++;
    if (dir_k != 1 || rise_k != 6 || position !== start + 32'd1) begin
      failures++;
      $display("FAIL dirchg_timing dir_k=%0d rise_k=%0d pos=%h exp 1 6 %h", dir_k, rise_k, position, start + 32'd1);
    end
  endtask

  task automatic test_overrun();
    int rises = 0;
    logic prev = step_out;
    pulse_len = 4; dir_in = 1;
    for (int k = 0; k < 25; k++) begin
      step_stb = (k < 3);
      @(posedge clk); @(negedge clk);
      if (step_out && !prev) rises++;
      prev = step_out;
      if (k == 2) begin
        checks++;
        if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_set got=%b exp=1", overrun); end
      end
      checks++;
      if ({step_out, dir_out, busy, overrun, position} !== {e_step, e_dir, e_busy, e_ovr, e_pos}) begin
        failures++;
        $display("FAIL overrun_cycle%0d got=%h exp=%h", k, {step_out, dir_out, busy, overrun, position}, {e_step, e_dir, e_busy, e_ovr, e_pos});
      end
    end
    step_stb = 0; clr_err = 1;
    @(posedge clk); @(negedge clk);
    clr_err = 0;
    checks++;
    if (rises != 2 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL overrun_clear rises=%0d ovr=%b exp 2 0", rises, overrun);
    end
  endtask

  task automatic test_back_to_back();
    pulse_len = 4; dir_in = 1;
    for (int s = 0; s < 2; s++) begin
      logic [31:0] start = position;
      for (int k = 0; k < 400; k++) begin
        step_stb = (k % 20 == 0);
        @(posedge clk); @(negedge clk);
        checks++;
        if ({step_out, dir_out, busy, overrun, position} !== {e_step, e_dir, e_busy, e_ovr, e_pos}) begin
          failures++;
          $display("FAIL chain_s%0d_c%0d got=%h exp=%h", s, k, {step_out, dir_out, busy, overrun, position}, {e_step, e_dir, e_busy, e_ovr, e_pos});
        end
      end
      step_stb = 0;
      checks++;
      if (position !== start + 32'd20 || overrun !== 1'b0) begin
        failures++;
        $display("FAIL chain_segment%0d pos=%h ovr=%b exp %h 0", s, position, overrun, start + 32'd20);
      end
    end
  endtask

  task automatic test_load_reset();
    repeat (3) @(negedge clk);
    pulse_len = 4; dir_in = 1; step_stb = 1;
    @(posedge clk); @(negedge clk);
    step_stb = 0; pos_load = 1; pos_val = 32'd1000;
    @(posedge clk); @(negedge clk);
    pos_load = 0;
    checks++;
    if (position !== 32'd1000 || step_out !== 1'b1) begin
      failures++;
      $display("FAIL load_collision pos=%0d step=%b exp 1000 1", position, step_out);
    end
    @(posedge clk); @(negedge clk);
    reset = 1;
    @(posedge clk); @(negedge clk);
    checks++;
    if ({step_out, dir_out, busy, overrun, position} !== 36'd0) begin
      failures++;
      $display("FAIL midpulse_reset got=%h exp=0", {step_out, dir_out, busy, overrun, position});
    end
    reset = 0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      step_stb  = ($urandom_range(0, 5) == 0);
      dir_in    = $urandom_range(0, 1);
      pulse_len = 16'($urandom_range(0, 4));
      setup_len = 16'($urandom_range(0, 4));
      pos_load  = ($urandom_range(0, 60) == 0);
      pos_val   = $urandom;
      clr_err   = ($urandom_range(0, 20) == 0);
      reset     = ($urandom_range(0, 400) == 0);
      @(posedge clk); @(negedge clk);
      checks++;
      if ({step_out, dir_out, busy, overrun, position} !== {e_step, e_dir, e_busy, e_ovr, e_pos}) begin
        failures++;
        $display("FAIL random_cycle%0d got=%h exp=%h", k, {step_out, dir_out, busy, overrun, position}, {e_step, e_dir, e_busy, e_ovr, e_pos});
      end
    end
    reset = 0;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_dir_change();
    test_overrun();
    test_back_to_back();
    test_load_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/step_pulse_out.md
# step_pulse_out

Output stage placed directly downstream of `acc_step_gen`. It turns that block's single-cycle `step_stb` into a driver-compatible STEP pulse with a programmable high/low width. It sequences the DIR line with a programmable setup time before any pulse of changed direction. It also keeps the signed absolute axis position.

## Interface
Parameters:
- `CNT_W`, 16: width of the pulse/setup length registers and timing counter.
- `POS_W`, 32: width of the position counter.

Ports:
- `clk` in 1: system clock; everything is in this domain.
- `reset` in 1: synchronous, active-high reset.
- `step_stb` in 1: one-cycle step request, from `acc_step_gen.step_stb`.
- `dir_in` in 1: requested direction, sampled with `step_stb`; 1 = positive.
- `pulse_len` in CNT_W: STEP high time in clocks, also the STEP low time; 0 is treated as 1.
- `setup_len` in CNT_W: DIR-to-STEP setup time in clocks; 0 is treated as 1.
- `pos_load` in 1: load `position` from `pos_val`.
- `pos_val` in POS_W: preset value for `position`.
- `clr_err` in 1: clear the sticky `overrun` flag.
- `step_out` out 1: STEP pin, registered.
- `dir_out` out 1: DIR pin, registered.
- `position` out POS_W: signed position, two's complement.
- `busy` out 1: high when the FSM is not in IDLE or a request is latched.
- `overrun` out 1: sticky flag; a step was dropped.

## Operation
- **Request latch.** The latch is one deep and holds `req`/`req_dir`.
  - `step_stb`=1 sets `req` and captures `dir_in` into `req_dir`.
  - If `req` is already set and is not consumed this cycle, the new step is dropped and `overrun` is set. `req_dir` is not overwritten.
  - Consume and set in the same cycle: the new request is accepted and there is no overrun.
- **FSM states:** IDLE, SETUP, PULSE, LOW. There is one down-counter `cnt` (CNT_W bits). In each state below, L = max(len,1).
  - **IDLE**, `req`=1, `req_dir`==`dir_out`: consume `req`, go to PULSE, `step_out`<=1, `cnt`<=L(pulse_len)-1, update `position`.
  - **IDLE**, `req`=1, `req_dir`!=`dir_out`: consume `req`, `dir_out`<=`req_dir`, go to SETUP, `cnt`<=L(setup_len)-1.
  - **SETUP**: when `cnt`==0, go to PULSE with the same actions as the IDLE→PULSE transition. Otherwise decrement `cnt`.
  - **PULSE**: when `cnt`==0, `step_out`<=0, go to LOW, `cnt`<=L(pulse_len)-1. Otherwise decrement `cnt`.
  - **LOW**: when `cnt`==0, go to IDLE. Otherwise decrement `cnt`.
- **Length sampling.** `pulse_len` and `setup_len` are sampled at each counter load. Changing them mid-pulse affects only later loads.
- **Position.** `position` changes by +1 (`dir_out` = 1 after the update) or -1, on the edge where `step_out` rises. It wraps modulo 2^POS_W.
  - `pos_load` has priority over the increment in the same cycle; that step's increment is lost.
- **`dir_out` changes only** on the IDLE→SETUP transition, so it is never toggled while `step_out`=1 or during LOW.
- **`overrun`** stays set until `clr_err` or `reset`. A set event and `clr_err` in the same cycle leaves it set.
- **Reset.** Applies in any state, including mid-pulse. It forces `step_out`=0, `dir_out`=0, `position`=0, `overrun`=0, `busy`=0, `req`=0, and state IDLE. A pulse truncated by reset is acceptable.

## Timing
- **Latency.** `step_stb` is sampled high at edge E0 and `req` is set. If `dir_out` is unchanged, `step_out` goes high after edge E1, i.e. 2 edges after the strobe.
- **Latency with a direction change.** `dir_out` changes after E1 and `step_out` rises after E1+L(setup_len).
- **Widths.** STEP is high for L(pulse_len) clocks, then low for L(pulse_len) clocks, then one IDLE cycle.
- **Sustained rate.** The minimum same-direction step spacing is 2·L(pulse_len)+1 clocks. `acc_step_gen` dt below this fills the latch and eventually sets `overrun`.
- **`position`** updates on the same edge as the rising `step_out`.
- **`busy`** is combinational from state and `req`. It is high from the cycle after `step_stb` until the cycle after LOW exits with no `req`.

## Test plan
- **Reset values.** Hold `reset` for 2 cycles, then release → all outputs 0, state IDLE.
- **Single step, same direction.** `pulse_len`=3, `dir_in`=0, one `step_stb` → `step_out` high for 3 clocks starting 2 edges after the strobe, then low for 3 clocks. `position`=-1 and `dir_out`=0 throughout. `busy` falls after 8 clocks.
- **Direction change.** `setup_len`=5, `pulse_len`=2, `dir_in`=1 with `dir_out`=0 → `dir_out` rises 2 edges after the strobe. `step_out` rises exactly 5 clocks later. `position`=+1.
- **Overrun.** `pulse_len`=4, three strobes 1 clock apart → two pulses are produced and `overrun`=1 after the third strobe. `clr_err` → `overrun`=0.
- **Back-to-back chain.** Drive from `acc_step_gen` with `dt_val`=20, `steps_val`=20, `load` tied to `done`, and `pulse_len`=4 → 20 pulses per segment, no overrun, `position` increases by 20 per segment.
- **Load collision and mid-pulse reset.** `pos_load` with `pos_val`=1000 on the edge where `step_out` rises → `position`=1000. Assert `reset` during PULSE → `step_out`=0 on the next edge.
